// File: rtl/regfile_writeback.sv
// Writeback driver for the register file: extends sub-word loads, merges LWL/LWR
// against the old register value, and drives write port 3 with a one-cycle pulse.
module regfile_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_dest_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [2:0]        req_mode_i,
  input  logic [1:0]        req_off_i,
  output logic [ADDR_W-1:0] rf_read_addr_o,
  input  logic [DATA_W-1:0] rf_read_data_i,
  output logic [ADDR_W-1:0] rf_addr_3_o,
  output logic [DATA_W-1:0] rf_write_data_3_o,
  output logic              rf_write_enable_o,
  output logic              pending_valid_o,
  output logic [ADDR_W-1:0] pending_dest_o,
  output logic              error_o
);

  localparam logic [2:0] M_WORD = 3'd0, M_BYTE_S = 3'd1, M_BYTE_U = 3'd2,
                         M_HALF_S = 3'd3, M_HALF_U = 3'd4, M_MERGE_L = 3'd5,
                         M_MERGE_R = 3'd6, M_RSVD = 3'd7;

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] read_addr_d, addr_d, pend_dest_d;
  logic [DATA_W-1:0] wdata_d, mem_q, mem_d, old;
  logic              we_d, pend_valid_d, err_d;
  logic              left_q, left_d;
  logic [1:0]        moff_q, moff_d;
  logic              after_commit;
  logic              accept, bad, is_merge;

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] mode, input logic [1:0] off,
                                              input logic [DATA_W-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (mode)
      M_BYTE_S: extend = {{(DATA_W-8){b[7]}}, b};
      M_BYTE_U: extend = {{(DATA_W-8){1'b0}}, b};
      M_HALF_S: extend = {{(DATA_W-16){h[15]}}, h};
      M_HALF_U: extend = {{(DATA_W-16){1'b0}}, h};
      default:  extend = d;
    endcase
  endfunction

  // Big-endian partial-word merge; for LWR the shift amount 8*(3-off) is {~off,3'b0}.
  function automatic logic [DATA_W-1:0] merge(input logic left, input logic [1:0] off,
                                             input logic [DATA_W-1:0] mem,
                                             input logic [DATA_W-1:0] prev);
    if (left)
      merge = (mem << {off, 3'b000}) | (prev & ~({DATA_W{1'b1}} << {off, 3'b000}));
    else
      merge = (mem >> {~off, 3'b000}) | (prev & ~({DATA_W{1'b1}} >> {~off, 3'b000}));
  endfunction

  assign req_ready_o = reset_n_i && (state != FETCH);
  assign accept      = req_valid_i && req_ready_o;
  assign is_merge    = (req_mode_i == M_MERGE_L) || (req_mode_i == M_MERGE_R);
  assign bad         = (req_mode_i == M_RSVD) ||
                       (((req_mode_i == M_HALF_S) || (req_mode_i == M_HALF_U)) && req_off_i[0]);

  // The write just pulsed has not reached the array yet, so forward it.
  assign old = (after_commit && (rf_addr_3_o == pending_dest_o)) ? rf_write_data_3_o
                                                                  : rf_read_data_i;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d      = state;
    read_addr_d  = rf_read_addr_o;
    addr_d       = rf_addr_3_o;
    wdata_d      = rf_write_data_3_o;
    we_d         = 1'b0;
    pend_valid_d = pending_valid_o;
    pend_dest_d  = pending_dest_o;
    err_d        = 1'b0;
    mem_d        = mem_q;
    left_d       = left_q;
    moff_d       = moff_q;
    case (state)
      FETCH: begin
        we_d    = 1'b1;
        addr_d  = pending_dest_o;
        wdata_d = merge(left_q, moff_q, mem_q, old);
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d      = IDLE;
        pend_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (bad || (req_dest_i == '0)) begin
        err_d        = bad;
        state_d      = IDLE;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
        pend_dest_d  = req_dest_i;
        if (is_merge) begin
          read_addr_d = req_dest_i;
          mem_d       = req_data_i;
          left_d      = (req_mode_i == M_MERGE_L);
          moff_d      = req_off_i;
          state_d     = FETCH;
        end else begin
          addr_d  = req_dest_i;
          wdata_d = extend(req_mode_i, req_off_i, req_data_i);
          we_d    = 1'b1;
          state_d = COMMIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rf_read_addr_o    <= '0;
      rf_addr_3_o       <= '0;
      rf_write_data_3_o <= '0;
      rf_write_enable_o <= 1'b0;
      pending_valid_o   <= 1'b0;
      pending_dest_o    <= '0;
      error_o           <= 1'b0;
      mem_q             <= '0;
      left_q            <= 1'b0;
      moff_q            <= '0;
      after_commit      <= 1'b0;
    end else begin
      rf_read_addr_o    <= read_addr_d;
      rf_addr_3_o       <= addr_d;
      rf_write_data_3_o <= wdata_d;
      rf_write_enable_o <= we_d;
      pending_valid_o   <= pend_valid_d;
      pending_dest_o    <= pend_dest_d;
      error_o           <= err_d;
      mem_q             <= mem_d;
      left_q            <= left_d;
      moff_q            <= moff_d;
      after_commit      <= (state == COMMIT);
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a regfile model whose writes land one
// cycle after the pulse, so merge forwarding is observable.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_dest = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_mode = '0;
  logic [1:0]  req_off = '0;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_addr_3;
  logic [31:0] rf_write_data_3;
  logic        rf_write_enable;
  logic        pending_valid;
  logic [4:0]  pending_dest;
  logic        error;

  regfile_writeback dut (
    .clk(clk), .reset_n_i(reset_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dest_i(req_dest), .req_data_i(req_data), .req_mode_i(req_mode), .req_off_i(req_off),
    .rf_read_addr_o(rf_read_addr), .rf_read_data_i(rf_read_data), .rf_addr_3_o(rf_addr_3),
    .rf_write_data_3_o(rf_write_data_3), .rf_write_enable_o(rf_write_enable),
    .pending_valid_o(pending_valid), .pending_dest_o(pending_dest), .error_o(error)
  );

  always #5 clk = ~clk;

  logic [31:0] rf_m [32];
  logic        preload = 1'b1;
  logic        lat_v;
  logic [4:0]  lat_a;
  logic [31:0] lat_d;

  always @(posedge clk) begin
    if (preload) begin
      for (int r = 0; r < 32; r++) rf_m[r] <= 32'h0;
      rf_m[5] <= 32'h11223344;
      rf_m[6] <= 32'h11223344;
      rf_m[8] <= 32'h11223344;
      rf_m[7] <= 32'hFFFFFFFF;
      lat_v   <= 1'b0;
    end else begin
      if (lat_v) rf_m[lat_a] <= lat_d;
      lat_v <= rf_write_enable;
      lat_a <= rf_addr_3;
      lat_d <= rf_write_data_3;
    end
  end

  assign rf_read_data = rf_m[rf_read_addr];

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [2:0]  mode;
    logic [1:0]  off;
    int          nwe;
    int          lat;
    logic [31:0] wdata;
    int          nerr;
    logic        pend1;
    logic        rdy1;
  } vec_t;

  vec_t tbl[13];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] d, input logic [31:0] x, input logic [2:0] m,
                       input logic [1:0] o);
    req_valid = 1'b1; req_dest = d; req_data = x; req_mode = m; req_off = o;
  endtask

  initial begin
    int nwe, lat, nerr;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        p1, r1;

    tbl[0]  = '{5'd4,  32'h80FF7F01, 3'd1, 2'd0, 1, 1, 32'hFFFFFF80, 0, 1'b1, 1'b1};
    tbl[1]  = '{5'd4,  32'h80FF7F01, 3'd2, 2'd2, 1, 1, 32'h0000007F, 0, 1'b1, 1'b1};
    tbl[2]  = '{5'd4,  32'h80FF7F01, 3'd3, 2'd2, 1, 1, 32'h00007F01, 0, 1'b1, 1'b1};
    tbl[3]  = '{5'd4,  32'h80FF7F01, 3'd4, 2'd0, 1, 1, 32'h000080FF, 0, 1'b1, 1'b1};
    tbl[4]  = '{5'd4,  32'h80FF7F01, 3'd3, 2'd1, 0, 0, 32'h0,        1, 1'b0, 1'b1};
    tbl[5]  = '{5'd4,  32'h80FF7F01, 3'd7, 2'd0, 0, 0, 32'h0,        1, 1'b0, 1'b1};
    tbl[6]  = '{5'd0,  32'h00000055, 3'd0, 2'd0, 0, 0, 32'h0,        0, 1'b0, 1'b1};
    tbl[7]  = '{5'd5,  32'hAABBCCDD, 3'd5, 2'd1, 1, 2, 32'hBBCCDD44, 0, 1'b1, 1'b0};
    tbl[8]  = '{5'd6,  32'hAABBCCDD, 3'd6, 2'd1, 1, 2, 32'h1122AABB, 0, 1'b1, 1'b0};
    tbl[9]  = '{5'd8,  32'hAABBCCDD, 3'd6, 2'd3, 1, 2, 32'hAABBCCDD, 0, 1'b1, 1'b0};
    tbl[10] = '{5'd10, 32'h12345678, 3'd0, 2'd3, 1, 1, 32'h12345678, 0, 1'b1, 1'b1};
    tbl[11] = '{5'd9,  32'h80FF7F01, 3'd1, 2'd3, 1, 1, 32'h00000001, 0, 1'b1, 1'b1};
    tbl[12] = '{5'd9,  32'h80FF7F01, 3'd4, 2'd2, 1, 1, 32'h00007F01, 0, 1'b1, 1'b1};

    // Reset held with a valid request pending: nothing may come out.
    drive(5'd3, 32'hDEADBEEF, 3'd0, 2'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'h0);
      chk("rst_ctl", {28'b0, rf_write_enable, pending_valid, error, |pending_dest}, 32'h0);
      chk("rst_data", {rf_write_data_3[31:10], rf_addr_3, rf_read_addr}, 32'h0);
    end
    preload = 1'b0;
    reset_n = 1'b1;
    #1 chk("rel_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("word_we", {31'b0, rf_write_enable}, 32'h1);
    chk("word_addr", {27'b0, rf_addr_3}, 32'd3);
    chk("word_data", rf_write_data_3, 32'hDEADBEEF);
    @(negedge clk);
    chk("word_we_drop", {31'b0, rf_write_enable}, 32'h0);
    repeat (2) @(negedge clk);
    chk("word_rf3", rf_m[3], 32'hDEADBEEF);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1 drive(tbl[i].dest, tbl[i].data, tbl[i].mode, tbl[i].off);
      @(posedge clk); #1 req_valid = 1'b0;
      nwe = 0; lat = 0; nerr = 0; wd = '0; wa = '0; p1 = 1'b0; r1 = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c == 1) begin p1 = pending_valid; r1 = req_ready; end
        if (rf_write_enable) begin
          nwe++;
          if (nwe == 1) begin lat = c; wd = rf_write_data_3; wa = rf_addr_3; end
        end
        if (error) nerr++;
      end
      chk($sformatf("v%0d_nwe", i), nwe, tbl[i].nwe);
      chk($sformatf("v%0d_err", i), nerr, tbl[i].nerr);
      chk($sformatf("v%0d_pend", i), {31'b0, p1}, {31'b0, tbl[i].pend1});
      chk($sformatf("v%0d_ready", i), {31'b0, r1}, {31'b0, tbl[i].rdy1});
      if (tbl[i].nwe > 0) begin
        chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
        chk($sformatf("v%0d_data", i), wd, tbl[i].wdata);
        chk($sformatf("v%0d_addr", i), {27'b0, wa}, {27'b0, tbl[i].dest});
      end
    end

    // WORD then MERGE_L to the same register on the next cycle: needs forwarding.
    @(posedge clk); #1 drive(5'd7, 32'h00000001, 3'd0, 2'd0);
    @(posedge clk); #1 drive(5'd7, 32'hAABBCCDD, 3'd5, 2'd2);
    @(negedge clk);
    chk("b2b_we1", {31'b0, rf_write_enable}, 32'h1);
    chk("b2b_data1", rf_write_data_3, 32'h00000001);
    chk("b2b_pd1", {27'b0, pending_dest}, 32'd7);
    chk("b2b_ready1", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_fetch_we", {31'b0, rf_write_enable}, 32'h0);
    chk("b2b_fetch_ready", {31'b0, req_ready}, 32'h0);
    chk("b2b_fetch_pend", {26'b0, pending_valid, pending_dest}, {26'b0, 1'b1, 5'd7});
    @(negedge clk);
    chk("b2b_we2", {31'b0, rf_write_enable}, 32'h1);
    chk("b2b_data2", rf_write_data_3, 32'hCCDD0001);
    chk("b2b_pd2", {26'b0, pending_valid, pending_dest}, {26'b0, 1'b1, 5'd7});
    @(negedge clk);
    chk("b2b_end", {30'b0, rf_write_enable, pending_valid}, 32'h0);

    // Two WORD writes back to back: one write per cycle.
    @(posedge clk); #1 drive(5'd11, 32'h0000000A, 3'd0, 2'd0);
    @(posedge clk); #1 drive(5'd12, 32'h0000000B, 3'd0, 2'd0);
    @(negedge clk);
    chk("ww_first", {rf_write_enable, rf_addr_3, rf_write_data_3[25:0]},
        {1'b1, 5'd11, 26'hA});
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("ww_second", {rf_write_enable, rf_addr_3, rf_write_data_3[25:0]},
        {1'b1, 5'd12, 26'hB});
    @(negedge clk);
    chk("ww_drop", {31'b0, rf_write_enable}, 32'h0);

    // Reset asserted while a merge is fetching: the write must never appear.
    @(posedge clk); #1 drive(5'd13, 32'hAABBCCDD, 3'd5, 2'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rf_fetch_ready", {31'b0, req_ready}, 32'h0);
    reset_n = 1'b0;
    nwe = 0;
    #1 chk("rf_rst_pend", {30'b0, pending_valid, rf_write_enable}, 32'h0);
    repeat (2) begin @(negedge clk); if (rf_write_enable) nwe++; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (rf_write_enable) nwe++; end
    chk("rf_no_write", nwe, 0);
    chk("rf_idle_ready", {31'b0, req_ready}, 32'h1);
    chk("rf_idle_pend", {31'b0, pending_valid}, 32'h0);
    chk("rf_reg13", rf_m[13], 32'h0);
    chk("reg0_zero", rf_m[0], 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
